dpmem_bist_ctrl: RTL and testbench

// Initiator-side controller for the 64x32 dual-port distributed memory (port A: a/d/we/spo,

---
 rtl/dpmem_bist_ctrl_if.sv | 23 ++
 rtl/dpmem_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_dpmem_bist_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dpmem_bist_ctrl_if.sv
// Bus between the BIST controller and the 64x32 dual-port distributed memory.
// Port A (a/d/we/spo) writes and reads; port DPRA (dpra/dpo) only reads.
interface dpmem_bist_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_dpra;
    logic [DATA_W-1:0] mem_spo;
    logic [DATA_W-1:0] mem_dpo;

    modport master (
        output mem_a, mem_d, mem_we, mem_dpra,
        input  mem_spo, mem_dpo
    );

    modport slave (
        input  mem_a, mem_d, mem_we, mem_dpra,
        output mem_spo, mem_dpo
    );
endinterface

// File: rtl/dpmem_bist_ctrl.sv
// Memory self-test: writes base+addr to every word, then reads both ports in opposite
// directions at once and reports pass, mismatch count and first failing address.
module dpmem_bist_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_base,
    dpmem_bist_ctrl_if.master   bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [ADDR_W+1:0]   o_err_cnt,
    output logic [ADDR_W-1:0]   o_err_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_base;
    logic [ADDR_W+1:0]   r_err_cnt;
    logic [ADDR_W-1:0]   r_err_addr;
    logic                r_pass;

    logic                w_accept;
    logic                w_last;
    logic                w_we;
    logic                w_busy;
    logic                w_done;
    logic [ADDR_W-1:0]   w_a;
    logic [ADDR_W-1:0]   w_dpra;
    logic [DATA_W-1:0]   w_d;
    logic                w_spo_err;
    logic                w_dpo_err;

    function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] b,
                                                   input logic [ADDR_W-1:0] x);
        return b + DATA_W'(x);
    endfunction

    // Holds at all-ones instead of wrapping; cannot trigger for a full run but guards reuse.
    function automatic logic [ADDR_W+1:0] sat_inc(input logic [ADDR_W+1:0] c,
                                                  input logic [1:0]        inc);
        logic [ADDR_W+2:0] s;
        s = (ADDR_W+3)'(c) + (ADDR_W+3)'(inc);
        return s[ADDR_W+2] ? '1 : s[ADDR_W+1:0];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_we     = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_a      = '0;
        w_d      = '0;
        w_dpra   = '0;
        w_last   = (r_addr == LAST);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = S_WRITE;
                end
            end
            S_WRITE: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                w_a    = r_addr;
                w_d    = exp_word(r_base, r_addr);
                w_dpra = r_addr;
                if (w_last) w_next = S_READ;
            end
            S_READ: begin
                w_busy = 1'b1;
                w_a    = r_addr;
                w_dpra = LAST - r_addr;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_spo_err = (r_state == S_READ) && (bus.mem_spo != exp_word(r_base, w_a));
    assign w_dpo_err = (r_state == S_READ) && (bus.mem_dpo != exp_word(r_base, w_dpra));

    // Seed register carries no reset; it is only ever used after an accepted start.
    always_ff @(posedge clk) begin
        if (w_accept) r_base <= i_base;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_pass     <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= '0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_pass     <= 1'b0;
        end else begin
            if (r_state == S_WRITE || r_state == S_READ)
                r_addr <= r_addr + 1'b1;
            if (r_state == S_READ) begin
                r_err_cnt <= sat_inc(r_err_cnt, {1'b0, w_spo_err} + {1'b0, w_dpo_err});
                // Only the first failing cycle of a run records an address; spo wins a tie.
                if (r_err_cnt == '0 && (w_spo_err || w_dpo_err))
                    r_err_addr <= w_spo_err ? w_a : w_dpra;
            end
            if (r_state == S_DONE)
                r_pass <= (r_err_cnt == '0);
        end
    end

    assign bus.mem_a    = w_a;
    assign bus.mem_d    = w_d;
    assign bus.mem_we   = w_we;
    assign bus.mem_dpra = w_dpra;
    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err_cnt;
    assign o_err_addr   = r_err_addr;
endmodule

// File: tb/tb_dpmem_bist_ctrl.sv
// Bench for dpmem_bist_ctrl: behavioural 64x32 dual-port memory with fault injection,
// a table of directed runs, random runs against a reference model, and reset abort.
module tb_dpmem_bist_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] base = '0;
    logic          busy, done, pass;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] err_addr;

    int            n_vec = 0;
    int            n_err = 0;

    // Fault kinds: 0 none, 1 stuck-at-1 on word, 2 stuck-at-0 on word,
    // 3 flip bits of word on dpo only, 4 flip bits of every word on both ports.
    int            f_kind = 0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_mask = '0;
    logic [DW-1:0] mem [DEPTH];

    dpmem_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dpmem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_start    (start),
        .i_base     (base),
        .bus        (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_err_cnt  (err_cnt),
        .o_err_addr (err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_fault(input bit dp, input logic [AW-1:0] w,
                                               input logic [DW-1:0] v, input int k,
                                               input logic [AW-1:0] fa, input logic [DW-1:0] m);
        case (k)
            1: if (w == fa) return v | m;
            2: if (w == fa) return v & ~m;
            3: if (dp && w == fa) return v ^ m;
            4: return v ^ m;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;
    assign bus.mem_spo = rd_fault(1'b0, bus.mem_a, mem[bus.mem_a], f_kind, f_addr, f_mask);
    assign bus.mem_dpo = rd_fault(1'b1, bus.mem_dpra, mem[bus.mem_dpra], f_kind, f_addr, f_mask);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference: every word holds base+x; the check scans x upward on spo and 63-x on dpo.
    task automatic model(input logic [DW-1:0] b, output bit e_pass, output int e_cnt,
                         output int e_addr);
        int first = -1;
        e_cnt = 0;
        for (int x = 0; x < DEPTH; x++) begin
            int y = DEPTH - 1 - x;
            logic [DW-1:0] ex = b + DW'(x);
            logic [DW-1:0] ey = b + DW'(y);
            if (rd_fault(1'b0, AW'(x), ex, f_kind, f_addr, f_mask) != ex) begin
                e_cnt++;
                if (first < 0) first = x;
            end
            if (rd_fault(1'b1, AW'(y), ey, f_kind, f_addr, f_mask) != ey) begin
                e_cnt++;
                if (first < 0) first = y;
            end
        end
        e_pass = (e_cnt == 0);
        e_addr = (first < 0) ? 0 : first;
    endtask

    task automatic run(input logic [DW-1:0] b, input bit extra, output int nbusy,
                       output int ndone, output int dk);
        @(negedge clk);
        base  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base  = $urandom;
        nbusy = 0;
        ndone = 0;
        dk    = 0;
        for (int k = 1; k <= 140; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (dk == 0) dk = k;
            end
            start = extra && (k == 10 || done);
            if (start) base = $urandom;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string nm, input logic [DW-1:0] b, input bit extra,
                             input bit e_pass, input int e_cnt, input int e_addr);
        int nb, nd, dk;
        run(b, extra, nb, nd, dk);
        chk({nm, ".busy_cycles"}, 32'(nb), 32'd128);
        chk({nm, ".done_pulses"}, 32'(nd), 32'd1);
        chk({nm, ".done_cycle"}, 32'(dk), 32'd129);
        chk({nm, ".pass"}, 32'(pass), 32'(e_pass));
        chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
        chk({nm, ".err_addr"}, 32'(err_addr), 32'(e_addr));
    endtask

    typedef struct {
        logic [DW-1:0] base;
        int            kind;
        logic [AW-1:0] fa;
        logic [DW-1:0] fm;
        bit            extra;
        bit            e_pass;
        int            e_cnt;
        int            e_addr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit   m_pass;
        int   m_cnt, m_addr;
        tbl[0] = '{32'h1000_0000, 0, 6'd0,  32'h0,         1'b0, 1'b1, 0,   0};
        tbl[1] = '{32'h0000_0000, 1, 6'd5,  32'h1,         1'b0, 1'b1, 0,   0};
        tbl[2] = '{32'h0000_0000, 2, 6'd5,  32'h1,         1'b0, 1'b0, 2,   5};
        tbl[3] = '{32'hFFFF_FFF0, 0, 6'd0,  32'h0,         1'b0, 1'b1, 0,   0};
        tbl[4] = '{32'hA5A5_0000, 0, 6'd0,  32'h0,         1'b1, 1'b1, 0,   0};
        tbl[5] = '{32'h0000_0000, 3, 6'd40, 32'h1,         1'b0, 1'b0, 1,   40};
        tbl[6] = '{32'h1234_5678, 2, 6'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 2,   0};
        tbl[7] = '{32'h0000_0000, 4, 6'd0,  32'h8000_0000, 1'b0, 1'b0, 128, 0};
        tbl[8] = '{32'h0000_0000, 3, 6'd63, 32'h2,         1'b0, 1'b0, 1,   63};

        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.err_addr", 32'(err_addr), 32'd0);
        chk("rst.we", 32'(bus.mem_we), 32'd0);
        chk("rst.a", 32'(bus.mem_a), 32'd0);
        chk("rst.dpra", 32'(bus.mem_dpra), 32'd0);
        chk("rst.d", bus.mem_d, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            f_kind = tbl[i].kind;
            f_addr = tbl[i].fa;
            f_mask = tbl[i].fm;
            check_run($sformatf("tbl%0d", i), tbl[i].base, tbl[i].extra,
                      tbl[i].e_pass, tbl[i].e_cnt, tbl[i].e_addr);
            if (i == 3) chk("tbl3.mem63", mem[63], 32'h0000_002F);
        end

        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] b;
            b      = $urandom;
            f_kind = $urandom_range(0, 4);
            f_addr = AW'($urandom_range(0, DEPTH - 1));
            f_mask = 32'h1 << $urandom_range(0, 31);
            model(b, m_pass, m_cnt, m_addr);
            check_run($sformatf("rnd%0d", i), b, 1'b0, m_pass, m_cnt, m_addr);
        end

        // Abort in READ at addr 20 with every word failing, so err_cnt is nonzero beforehand.
        f_kind = 4;
        f_mask = 32'h1;
        @(negedge clk);
        base  = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (84) @(negedge clk);
        chk("abort.a", 32'(bus.mem_a), 32'd20);
        chk("abort.dpra", 32'(bus.mem_dpra), 32'd43);
        chk("abort.busy_pre", 32'(busy), 32'd1);
        chk("abort.err_cnt_pre", 32'(err_cnt), 32'd40);
        #1 rstn = 1'b0;
        #1;
        chk("abort.we", 32'(bus.mem_we), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.pass", 32'(pass), 32'd0);
        chk("abort.err_cnt", 32'(err_cnt), 32'd0);
        chk("abort.err_addr", 32'(err_addr), 32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        f_kind = 0;
        check_run("after_abort", 32'h5555_AAAA, 1'b0, 1'b1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
